// File: rtl/video_timing_analyzer.sv
// Raster geometry analyzer with a frame-based lock FSM.
// Optional per-frame clk counter is built when VTA_FRAME_CLKS_EN is defined.
module video_timing_analyzer #(
    parameter int CNT_W        = 12,
    parameter int LOCK_FRAMES  = 3,
    parameter int TIMEOUT_CLKS = 4194304
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             hblank,
    input  logic             vblank,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] v_total,
    output logic [CNT_W-1:0] v_active,
    output logic             hs_pol,
    output logic             vs_pol,
    output logic             interlaced,
    output logic             locked,
    output logic             changed,
    output logic [31:0]      frame_clks
);

    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] CMAX     = '1;
    localparam logic [CNT_W-1:0] ONE      = 1;
    localparam logic [CNT_W:0]   ONE_X    = 1;
    localparam logic [TW-1:0]    ONE_T    = 1;
    localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {S_UNLOCK, S_MEAS, S_LOCKED} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CMAX) ? v : v + ONE;
    endfunction

    logic ce_r, hsync_r, vsync_r, hblank_r, vblank_r;
    logic pol_h, pol_v, hs_d, vs_d, sat_f;
    logic [CNT_W-1:0] hcnt, dcnt, line_tot, vcnt, vact, amax;
    logic [TW-1:0] tmo;

    logic de, hs_a, vs_a, line_end, frame_end, timeout;
    logic [CNT_W-1:0] tot_n, vcnt_n, vact_n, amax_n, vmax;
    logic sat_n;

    assign de        = ce_r & ~(hblank_r | vblank_r);
    assign hs_a      = hsync_r ~^ pol_h;
    assign vs_a      = vsync_r ~^ pol_v;
    assign line_end  = hs_a & ~hs_d;
    assign frame_end = vs_a & ~vs_d;
    assign timeout   = (tmo == TMO_LAST) & ~frame_end;

    // Frame totals as they stand including a line ending on this clk.
    assign tot_n  = line_end ? hcnt : line_tot;
    assign vcnt_n = line_end ? sat_inc(vcnt) : vcnt;
    assign vact_n = (line_end && dcnt != '0) ? sat_inc(vact) : vact;
    assign amax_n = (line_end && dcnt > amax) ? dcnt : amax;
    assign sat_n  = sat_f | (hcnt == CMAX) | (tot_n == CMAX)
                  | (vcnt_n == CMAX) | (vact_n == CMAX);

    // Edge history resets to "sync active" so no edge fires on release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ce_r     <= 1'b0;
            hsync_r  <= 1'b0;
            vsync_r  <= 1'b0;
            hblank_r <= 1'b0;
            vblank_r <= 1'b0;
            hs_d     <= 1'b1;
            vs_d     <= 1'b1;
            pol_h    <= 1'b0;
            pol_v    <= 1'b0;
            hcnt     <= '0;
            dcnt     <= '0;
            line_tot <= '0;
            vcnt     <= '0;
            vact     <= '0;
            amax     <= '0;
            sat_f    <= 1'b0;
            tmo      <= '0;
        end else begin
            ce_r     <= ce_pix;
            hsync_r  <= hsync;
            vsync_r  <= vsync;
            hblank_r <= hblank;
            vblank_r <= vblank;
            hs_d     <= hs_a;
            vs_d     <= vs_a;
            if (de && (dcnt == '0 || line_end)) begin
                pol_h <= ~hsync_r;
                pol_v <= ~vsync_r;
            end
            line_tot <= tot_n;
            if (line_end) begin
                hcnt <= {{(CNT_W-1){1'b0}}, ce_r};
                dcnt <= {{(CNT_W-1){1'b0}}, de};
            end else begin
                if (ce_r) hcnt <= sat_inc(hcnt);
                if (de)   dcnt <= sat_inc(dcnt);
            end
            if (frame_end) begin
                vcnt  <= '0;
                vact  <= '0;
                amax  <= '0;
                sat_f <= 1'b0;
            end else begin
                vcnt  <= vcnt_n;
                vact  <= vact_n;
                amax  <= amax_n;
                sat_f <= sat_n;
            end
            tmo <= (frame_end || timeout) ? '0 : tmo + ONE_T;
        end
    end

    state_t st;
    logic [3:0] mcnt;
    logic run, p_valid, p_sat, p_hs, p_vs;
    logic [CNT_W-1:0] p_tot, p_amax, p_vcnt, p_vact;
    logic vdiff_one, match, hit, commit;
    logic [CNT_W:0] vn_x, pv_x;

    assign vn_x      = {1'b0, vcnt_n};
    assign pv_x      = {1'b0, p_vcnt};
    assign vdiff_one = (vn_x == pv_x + ONE_X) || (pv_x == vn_x + ONE_X);
    assign vmax      = (vcnt_n > p_vcnt) ? vcnt_n : p_vcnt;
    assign match     = p_valid & ~p_sat & ~sat_n
                     & (tot_n == p_tot) & (amax_n == p_amax)
                     & (vact_n == p_vact) & (pol_h == p_hs) & (pol_v == p_vs)
                     & ((vcnt_n == p_vcnt) | vdiff_one);
    assign hit       = (int'(mcnt) + 1) >= (LOCK_FRAMES - 1);
    assign commit    = frame_end & match
                     & (((st == S_MEAS) & hit) | (st == S_LOCKED));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st         <= S_UNLOCK;
            mcnt       <= '0;
            run        <= 1'b0;
            p_valid    <= 1'b0;
            p_sat      <= 1'b0;
            p_hs       <= 1'b0;
            p_vs       <= 1'b0;
            p_tot      <= '0;
            p_amax     <= '0;
            p_vcnt     <= '0;
            p_vact     <= '0;
            h_total    <= '0;
            h_active   <= '0;
            v_total    <= '0;
            v_active   <= '0;
            hs_pol     <= 1'b0;
            vs_pol     <= 1'b0;
            interlaced <= 1'b0;
            locked     <= 1'b0;
            changed    <= 1'b0;
        end else begin
            changed <= 1'b0;
            if (timeout) begin
                st         <= S_UNLOCK;
                mcnt       <= '0;
                run        <= 1'b0;
                p_valid    <= 1'b0;
                h_total    <= '0;
                h_active   <= '0;
                v_total    <= '0;
                v_active   <= '0;
                hs_pol     <= 1'b0;
                vs_pol     <= 1'b0;
                interlaced <= 1'b0;
                locked     <= 1'b0;
                changed    <= locked;
            end else if (frame_end) begin
                run     <= 1'b1;
                p_valid <= 1'b1;
                p_sat   <= sat_n;
                p_hs    <= pol_h;
                p_vs    <= pol_v;
                p_tot   <= tot_n;
                p_amax  <= amax_n;
                p_vcnt  <= vcnt_n;
                p_vact  <= vact_n;
                unique case (st)
                    S_UNLOCK: begin
                        st      <= S_MEAS;
                        mcnt    <= '0;
                        p_valid <= run;
                    end
                    S_MEAS: begin
                        if (!match) begin
                            mcnt <= '0;
                        end else if (hit) begin
                            st      <= S_LOCKED;
                            locked  <= 1'b1;
                            changed <= 1'b1;
                        end else begin
                            mcnt <= mcnt + 4'd1;
                        end
                    end
                    S_LOCKED: begin
                        if (!match) begin
                            st      <= S_UNLOCK;
                            mcnt    <= '0;
                            locked  <= 1'b0;
                            changed <= 1'b1;
                        end
                    end
                    default: st <= S_UNLOCK;
                endcase
                if (commit) begin
                    h_total    <= tot_n;
                    h_active   <= amax_n;
                    v_total    <= vmax;
                    v_active   <= vact_n;
                    hs_pol     <= pol_h;
                    vs_pol     <= pol_v;
                    interlaced <= vdiff_one;
                end
            end
        end
    end

`ifdef VTA_FRAME_CLKS_EN
    logic [31:0] fcnt, fcnt_n;

    assign fcnt_n = (fcnt == 32'hFFFF_FFFF) ? fcnt : fcnt + 32'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fcnt       <= '0;
            frame_clks <= '0;
        end else begin
            fcnt <= frame_end ? '0 : fcnt_n;
            if (timeout)     frame_clks <= '0;
            else if (commit) frame_clks <= fcnt_n;
        end
    end
`else
    assign frame_clks = '0;
`endif

endmodule

// File: tb/tb_video_timing_analyzer.sv
// Directed bench for video_timing_analyzer: lock, polarity, change,
// interlace, timeout and asynchronous reset scenarios.
module tb_video_timing_analyzer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce_pix = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic        hblank = 1'b1;
    logic        vblank = 1'b1;
    logic [11:0] h_total, h_active, v_total, v_active;
    logic        hs_pol, vs_pol, interlaced, locked, changed;
    logic [31:0] frame_clks;

    int checks = 0;
    int errors = 0;
    int chg_cnt = 0;
    int c0;

    video_timing_analyzer #(
        .CNT_W(12), .LOCK_FRAMES(3), .TIMEOUT_CLKS(1000)
    ) dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix),
        .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
        .h_total(h_total), .h_active(h_active),
        .v_total(v_total), .v_active(v_active),
        .hs_pol(hs_pol), .vs_pol(vs_pol), .interlaced(interlaced),
        .locked(locked), .changed(changed), .frame_clks(frame_clks)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (changed === 1'b1) chg_cnt++;

    // 16 active pixels, hsync two pixels before line end,
    // 8 active lines, vsync over lines 9-10; ce_pix every 2 clks.
    task automatic drive_frame(input int hpix, input int nl,
                               input bit hi, input bit vs_on);
        for (int l = 0; l < nl; l++) begin
            for (int p = 0; p < hpix; p++) begin
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    ce_pix = (c == 0);
                    hblank = (p >= 16);
                    vblank = (l >= 8);
                    hsync  = hi ~^ ((p == hpix - 3) || (p == hpix - 2));
                    vsync  = hi ~^ (vs_on && (l == 9 || l == 10));
                end
            end
        end
    endtask

    task automatic do_reset(input bit hi);
        @(negedge clk);
        reset = 1'b1;
        ce_pix = 1'b0;
        hblank = 1'b1;
        vblank = 1'b1;
        hsync = ~hi;
        vsync = ~hi;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0b want 0", locked); end
        checks++; if (changed !== 1'b0) begin errors++; $display("FAIL reset_changed got %0b want 0", changed); end
        checks++; if (h_total !== 12'd0) begin errors++; $display("FAIL reset_h_total got %0d want 0", h_total); end
        checks++; if (v_total !== 12'd0) begin errors++; $display("FAIL reset_v_total got %0d want 0", v_total); end
        checks++; if (frame_clks !== 32'd0) begin errors++; $display("FAIL reset_frame_clks got %0d want 0", frame_clks); end
        reset = 1'b0;
    endtask

    task automatic test_lock_low;
        c0 = chg_cnt;
        repeat (3) drive_frame(20, 12, 1'b0, 1'b1);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL low_early_lock got %0b want 0", locked); end
        drive_frame(20, 12, 1'b0, 1'b1);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL low_locked got %0b want 1", locked); end
        checks++; if (h_total !== 12'd20) begin errors++; $display("FAIL low_h_total got %0d want 20", h_total); end
        checks++; if (h_active !== 12'd16) begin errors++; $display("FAIL low_h_active got %0d want 16", h_active); end
        checks++; if (v_total !== 12'd12) begin errors++; $display("FAIL low_v_total got %0d want 12", v_total); end
        checks++; if (v_active !== 12'd8) begin errors++; $display("FAIL low_v_active got %0d want 8", v_active); end
        checks++; if (hs_pol !== 1'b0 || vs_pol !== 1'b0) begin errors++; $display("FAIL low_pol got %0b%0b want 00", hs_pol, vs_pol); end
        checks++; if (interlaced !== 1'b0) begin errors++; $display("FAIL low_interlaced got %0b want 0", interlaced); end
        checks++; if (chg_cnt - c0 != 1) begin errors++; $display("FAIL low_changed_pulses got %0d want 1", chg_cnt - c0); end
    endtask

    task automatic test_frame_clks;
`ifdef VTA_FRAME_CLKS_EN
        checks++; if (frame_clks !== 32'd480) begin errors++; $display("FAIL frame_clks got %0d want 480", frame_clks); end
`else
        checks++; if (frame_clks !== 32'd0) begin errors++; $display("FAIL frame_clks got %0d want 0", frame_clks); end
`endif
    endtask

    task automatic test_pol_high;
        do_reset(1'b1);
        repeat (4) drive_frame(20, 12, 1'b1, 1'b1);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL high_locked got %0b want 1", locked); end
        checks++; if (hs_pol !== 1'b1 || vs_pol !== 1'b1) begin errors++; $display("FAIL high_pol got %0b%0b want 11", hs_pol, vs_pol); end
        checks++; if (h_total !== 12'd20 || h_active !== 12'd16) begin errors++; $display("FAIL high_h got %0d/%0d want 20/16", h_total, h_active); end
        checks++; if (v_total !== 12'd12 || v_active !== 12'd8) begin errors++; $display("FAIL high_v got %0d/%0d want 12/8", v_total, v_active); end
    endtask

    task automatic test_h_change;
        c0 = chg_cnt;
        drive_frame(24, 12, 1'b1, 1'b1);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL hchg_unlock got %0b want 0", locked); end
        checks++; if (chg_cnt - c0 != 1) begin errors++; $display("FAIL hchg_pulse got %0d want 1", chg_cnt - c0); end
        checks++; if (h_total !== 12'd20) begin errors++; $display("FAIL hchg_hold got %0d want 20", h_total); end
        repeat (2) drive_frame(24, 12, 1'b1, 1'b1);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL hchg_early got %0b want 0", locked); end
        drive_frame(24, 12, 1'b1, 1'b1);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL hchg_relock got %0b want 1", locked); end
        checks++; if (h_total !== 12'd24) begin errors++; $display("FAIL hchg_h_total got %0d want 24", h_total); end
        checks++; if (chg_cnt - c0 != 2) begin errors++; $display("FAIL hchg_pulses got %0d want 2", chg_cnt - c0); end
    endtask

    task automatic test_interlace;
        c0 = chg_cnt;
        drive_frame(24, 13, 1'b1, 1'b1);
        drive_frame(24, 12, 1'b1, 1'b1);
        drive_frame(24, 13, 1'b1, 1'b1);
        drive_frame(24, 12, 1'b1, 1'b1);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL il_locked got %0b want 1", locked); end
        checks++; if (interlaced !== 1'b1) begin errors++; $display("FAIL il_flag got %0b want 1", interlaced); end
        checks++; if (v_total !== 12'd13) begin errors++; $display("FAIL il_v_total got %0d want 13", v_total); end
        checks++; if (v_active !== 12'd8) begin errors++; $display("FAIL il_v_active got %0d want 8", v_active); end
        checks++; if (chg_cnt != c0) begin errors++; $display("FAIL il_pulses got %0d want 0", chg_cnt - c0); end
    endtask

    task automatic test_timeout;
        c0 = chg_cnt;
        repeat (3) drive_frame(24, 12, 1'b1, 1'b0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL tmo_locked got %0b want 0", locked); end
        checks++; if (h_total !== 12'd0 || h_active !== 12'd0) begin errors++; $display("FAIL tmo_h got %0d/%0d want 0/0", h_total, h_active); end
        checks++; if (v_total !== 12'd0 || v_active !== 12'd0) begin errors++; $display("FAIL tmo_v got %0d/%0d want 0/0", v_total, v_active); end
        checks++; if (hs_pol !== 1'b0 || vs_pol !== 1'b0 || interlaced !== 1'b0) begin errors++; $display("FAIL tmo_flags got %0b%0b%0b want 000", hs_pol, vs_pol, interlaced); end
        checks++; if (frame_clks !== 32'd0) begin errors++; $display("FAIL tmo_frame_clks got %0d want 0", frame_clks); end
        checks++; if (chg_cnt - c0 != 1) begin errors++; $display("FAIL tmo_pulse got %0d want 1", chg_cnt - c0); end
    endtask

    task automatic test_reset_mid;
        repeat (4) drive_frame(20, 12, 1'b1, 1'b1);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL mid_pre_lock got %0b want 1", locked); end
        for (int p = 0; p < 10; p++) begin
            @(negedge clk); ce_pix = 1'b1; hblank = 1'b0; vblank = 1'b0;
            @(negedge clk); ce_pix = 1'b0;
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mid_locked got %0b want 0", locked); end
        checks++; if (h_total !== 12'd0 || v_total !== 12'd0) begin errors++; $display("FAIL mid_totals got %0d/%0d want 0/0", h_total, v_total); end
        checks++; if (hs_pol !== 1'b0 || vs_pol !== 1'b0) begin errors++; $display("FAIL mid_pol got %0b%0b want 00", hs_pol, vs_pol); end
        do_reset(1'b1);
        repeat (4) drive_frame(20, 12, 1'b1, 1'b1);
        checks++; if (locked !== 1'b1 || h_total !== 12'd20) begin errors++; $display("FAIL mid_resume got %0b/%0d want 1/20", locked, h_total); end
    endtask

    initial begin
        test_reset;
        test_lock_low;
        test_frame_clks;
        test_pol_high;
        test_h_change;
        test_interlace;
        test_timeout;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
